// File: rtl/program_loader.sv
// Streams words into the core's instruction/data memory, optionally packing
// instruction fields into the core's format, and holds the core until the load completes.
module program_loader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_raw,
    input  logic [31:0]       in_word,
    input  logic [5:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              mem_write_enable,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [5:0]        word_count
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                last_q, last_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                cpu_run_q, cpu_run_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [5:0]          word_count_q, word_count_d;
    logic [31:0]         enc_word;

    // Must stay the exact inverse of the core's decoder.
    always_comb begin
        enc_word = in_word;
        if (!in_raw) begin
            if (in_opcode == 6'd20 || in_opcode == 6'd21)
                enc_word = {in_opcode, 10'b0, in_imm};
            else if (in_opcode == 6'd63)
                enc_word = {6'h3F, 26'b0};
            else
                enc_word = {in_opcode, in_rd, in_rs, in_imm};
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_d       = last_q;
        in_ready_d   = in_ready_q;
        we_d         = we_q;
        mode_d       = mode_q;
        mem_addr_d   = mem_addr_q;
        data_d       = data_q;
        cpu_run_d    = cpu_run_q;
        busy_d       = busy_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = LOAD;
                    addr_d       = FIRST_ADDR;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                    cpu_run_d    = 1'b0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    in_ready_d   = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid && in_ready_q) begin
                    state_d    = WRITE;
                    mem_addr_d = addr_q;
                    data_d     = DATA_W'(enc_word);
                    last_d     = in_last;
                    mode_d     = 1'b0;
                    we_d       = 1'b1;
                    in_ready_d = 1'b0;
                end
            end
            WRITE: begin
                mode_d       = 1'b1;
                we_d         = 1'b0;
                addr_d       = addr_q + 1'b1;
                word_count_d = word_count_q + 6'd1;
                // The address never wraps: the top slot always ends the load.
                if (last_q || addr_q == LAST_ADDR) begin
                    state_d    = DONE;
                    overflow_d = !last_q;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    cpu_run_d  = 1'b1;
                    in_ready_d = 1'b0;
                end else begin
                    state_d    = LOAD;
                    in_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            mode_q       <= 1'b1;
            mem_addr_q   <= '0;
            data_q       <= '0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            in_ready_q   <= in_ready_d;
            we_q         <= we_d;
            mode_q       <= mode_d;
            mem_addr_q   <= mem_addr_d;
            data_q       <= data_d;
            cpu_run_q    <= cpu_run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign mem_write_enable = we_q;
    assign mem_mode         = mode_q;
    assign mem_addr         = mem_addr_q;
    assign mem_data_in      = data_q;
    assign cpu_run          = cpu_run_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign overflow         = overflow_q;
    assign word_count       = word_count_q;
endmodule
